// File: rtl/mux_rr_nto1_if.sv
// Stream bundle for mux_rr_nto1: NCH producer channels in, one consumer channel out.
// slave  = the multiplexer's view, master = the producers/consumer driving it.
interface mux_rr_nto1_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_rr_nto1.sv
// Registered N-to-1 stream multiplexer with fixed-select (op=0) and round-robin (op=1) modes.
// One output register stage; full throughput when the consumer keeps out_ready high.
// Optional transfer counter built only when MUX_RR_XFER_CNT_EN is defined; otherwise
// xfer_cnt is tied to zero and the port list is unchanged.
module mux_rr_nto1 #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op,
  input  logic [SELW-1:0]  sel,
  mux_rr_nto1_if.slave     bus,
  output logic [15:0]      xfer_cnt
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  grant;
  logic             grant_vld;
  logic             load_en;
  logic             accept;
  logic [WIDTH-1:0] data_sel;
  int               idx;
  logic [SELW-1:0]  idx_s;

  assign load_en = !bus.out_valid || bus.out_ready;
  assign accept  = load_en && grant_vld;

  // Grant selection: direct sel in fixed mode, first valid channel at or after ptr in round-robin.
  // The round-robin loop runs from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    idx_s     = '0;
    if (op) begin
      grant_vld = |bus.in_valid;
      for (int k = NCH - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= NCH) idx = idx - NCH;
        idx_s = SELW'(idx);
        if (bus.in_valid[idx_s]) grant = idx_s;
      end
    end else if (int'(sel) < NCH) begin
      grant     = sel;
      grant_vld = bus.in_valid[sel];
    end
  end

  // One-hot ready towards the granted producer; held off while reset is asserted so no word is taken.
  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.in_ready[i] = !rst && accept && (int'(grant) == i);
    end
  end

  // Data mux for the granted channel feeding the output register.
  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(grant) == i) data_sel = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register: load on accept, clear valid on drain-only, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= data_sel;
      bus.out_ch    <= grant;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Round-robin pointer: moves past the winner on each accepted round-robin transfer.
  // Explicit wrap keeps non-power-of-2 NCH from landing on an unused index.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept && op) begin
      ptr <= (int'(grant) == NCH - 1) ? '0 : grant + 1'b1;
    end
  end

`ifdef MUX_RR_XFER_CNT_EN
  logic [15:0] cnt;

  // Completed output transfers, free-running modulo 2^16.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign xfer_cnt = cnt;
`else
  assign xfer_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Directed bench for mux_rr_nto1 (WIDTH=8, NCH=4, SELW=2).
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_mux_rr_nto1;

  logic        clk = 1'b0;
  logic        rst;
  logic        op;
  logic [1:0]  sel;
  logic [15:0] xfer_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // channel data: ch3..ch0
  localparam logic [31:0] CH_DATA = {8'hD3, 8'hA5, 8'hC1, 8'hC0};
  logic [7:0] ch_byte [4];

  mux_rr_nto1_if #(.WIDTH(8), .NCH(4), .SELW(2)) bus ();

  mux_rr_nto1 #(.WIDTH(8), .NCH(4), .SELW(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .sel      (sel),
    .bus      (bus),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    ch_byte[0] = 8'hC0;
    ch_byte[1] = 8'hC1;
    ch_byte[2] = 8'hA5;
    ch_byte[3] = 8'hD3;

    // 1. reset with all channels valid
    rst           = 1'b1;
    op            = 1'b1;
    sel           = 2'd0;
    bus.in_data   = CH_DATA;
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b0;
    tick();
    settle();
    check_val("rst_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    check_val("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_val("rst_out_ch", 32'(bus.out_ch), 32'h0);
    check_val("rst_out_data", 32'(bus.out_data), 32'h0);
    check_val("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
    settle();
    check_val("rst_in_ready2", 32'(bus.in_ready), 32'h0);

    // release with nothing valid
    rst          = 1'b0;
    bus.in_valid = 4'h0;
    settle();
    check_val("idle_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    check_val("idle_out_valid", 32'(bus.out_valid), 32'h0);

    // 2. fixed mode, sel=2
    op            = 1'b0;
    sel           = 2'd2;
    bus.in_valid  = 4'b0110;
    bus.out_ready = 1'b1;
    settle();
    check_val("fix_in_ready", 32'(bus.in_ready), 32'b0100);
    tick();
    check_val("fix_out_data", 32'(bus.out_data), 32'hA5);
    check_val("fix_out_ch", 32'(bus.out_ch), 32'd2);
    check_val("fix_out_valid", 32'(bus.out_valid), 32'h1);

    // fixed mode on a channel that is not valid: nothing accepted, register drains
    sel = 2'd0;
    settle();
    check_val("fix_novld_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    check_val("drain_out_valid", 32'(bus.out_valid), 32'h0);
    check_val("drain_hold_data", 32'(bus.out_data), 32'hA5);
    check_val("drain_hold_ch", 32'(bus.out_ch), 32'd2);

    // 3. round-robin, all valid; ptr still 0 since fixed mode leaves it alone
    op           = 1'b1;
    bus.in_valid = 4'hF;
    settle();
    check_val("rr_first_ready", 32'(bus.in_ready), 32'b0001);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_val("rr_seq_ch", 32'(bus.out_ch), 32'(i % 4));
      check_val("rr_seq_data", 32'(bus.out_data), 32'(ch_byte[i % 4]));
      check_val("rr_seq_valid", 32'(bus.out_valid), 32'h1);
    end

    // 4. ptr=3 now; skip and wrap over channels 0 and 2
    bus.in_valid = 4'b0101;
    settle();
    check_val("rr_wrap_ready0", 32'(bus.in_ready), 32'b0001);
    tick();
    check_val("rr_wrap_ch0", 32'(bus.out_ch), 32'd0);
    settle();
    check_val("rr_skip_ready2", 32'(bus.in_ready), 32'b0100);
    tick();
    check_val("rr_skip_ch2", 32'(bus.out_ch), 32'd2);
    settle();
    check_val("rr_wrap_ready0b", 32'(bus.in_ready), 32'b0001);
    tick();
    check_val("rr_wrap_ch0b", 32'(bus.out_ch), 32'd0);
    check_val("rr_wrap_data", 32'(bus.out_data), 32'hC0);

    // 5. backpressure for 5 cycles, ptr=1
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_val("bp_in_ready", 32'(bus.in_ready), 32'h0);
      tick();
      check_val("bp_out_data", 32'(bus.out_data), 32'hC0);
      check_val("bp_out_ch", 32'(bus.out_ch), 32'd0);
      check_val("bp_out_valid", 32'(bus.out_valid), 32'h1);
    end
    bus.out_ready = 1'b1;
    settle();
    check_val("bp_release_ready", 32'(bus.in_ready), 32'b0100);
    tick();
    check_val("bp_reload_ch", 32'(bus.out_ch), 32'd2);
    check_val("bp_reload_data", 32'(bus.out_data), 32'hA5);
    check_val("bp_reload_valid", 32'(bus.out_valid), 32'h1);

    // reset drops the word held in the register
    rst = 1'b1;
    tick();
    check_val("rst2_out_valid", 32'(bus.out_valid), 32'h0);
    check_val("rst2_xfer_cnt", 32'(xfer_cnt), 32'h0);

    // 6. 70000 output transfers: first tick only loads, every later tick drains one word
    rst           = 1'b0;
    op            = 1'b1;
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 70001; i++) tick();
`ifdef MUX_RR_XFER_CNT_EN
    check_val("xfer_cnt_wrap", 32'(xfer_cnt), 32'd4464);
`else
    check_val("xfer_cnt_off", 32'(xfer_cnt), 32'd0);
`endif
    // 70001 accepts from ptr=0 -> last granted channel is 70000 mod 4 = 0
    check_val("long_run_ch", 32'(bus.out_ch), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
